// File: rtl/multi_acc_if.sv
// Handshake bundle for multi_acc: an input transaction channel and a result channel.
// The master modport is the traffic source/sink; the slave modport is the accumulator block.
interface multi_acc_if #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 4,
   parameter int ACC_WIDTH = 16
);
   localparam int CH_W = $clog2(CHANNELS);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic [1:0]           in_op;
   logic [CH_W-1:0]      in_ch;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_data;
   logic [CH_W-1:0]      out_ch;
   logic                 out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_op, in_ch, out_ready,
      input  in_ready, out_valid, out_data, out_ch, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_ch, out_ready,
      output in_ready, out_valid, out_data, out_ch, out_ovf
   );
endinterface

// File: rtl/multi_acc.sv
// Multi-channel accumulator with a one-deep result register and valid/ready on both sides.
// Define MULTI_ACC_SAT_EN to clamp overflowing ACC operations at all-ones instead of wrapping.
module multi_acc #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 4,
   parameter int ACC_WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   multi_acc_if.slave bus
);
   localparam int CH_W = $clog2(CHANNELS);

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_ACC  = 2'b01,
      OP_CLR  = 2'b10,
      OP_READ = 2'b11
   } op_e;

   op_e                  op;
   logic                 accept;
   logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
   logic [CHANNELS-1:0]  ovf_q;
   logic [ACC_WIDTH-1:0] sel_acc;
   logic                 sel_ovf;
   logic [WIDTH:0]       pair_sum;
   logic [ACC_WIDTH:0]   acc_sum;
   logic                 ovf_hit;
   logic [ACC_WIDTH-1:0] acc_next;
   logic                 ovf_next;
   logic [ACC_WIDTH-1:0] data_next;
   logic                 ovf_out_next;

   logic                 out_valid_reg;
   logic [ACC_WIDTH-1:0] out_data_reg;
   logic [CH_W-1:0]      out_ch_reg;
   logic                 out_ovf_reg;

   assign op           = op_e'(bus.in_op);
   assign bus.in_ready = ~out_valid_reg | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   assign sel_acc  = acc_q[bus.in_ch];
   assign sel_ovf  = ovf_q[bus.in_ch];
   assign pair_sum = {1'b0, bus.in_a} + {1'b0, bus.in_b};
   // ACC_WIDTH >= WIDTH+1, so one extra bit holds the full true sum.
   assign acc_sum  = {1'b0, sel_acc} + (ACC_WIDTH + 1)'(pair_sum);
   assign ovf_hit  = acc_sum[ACC_WIDTH];
   assign ovf_next = sel_ovf | ovf_hit;

`ifdef MULTI_ACC_SAT_EN
   assign acc_next = ovf_hit ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
`else
   assign acc_next = acc_sum[ACC_WIDTH-1:0];
`endif

   always_comb begin
      data_next    = '0;
      ovf_out_next = 1'b0;
      case (op)
         OP_ADD:  data_next = ACC_WIDTH'(pair_sum);
         OP_ACC: begin
            data_next    = acc_next;
            ovf_out_next = ovf_next;
         end
         OP_READ: begin
            data_next    = sel_acc;
            ovf_out_next = sel_ovf;
         end
         default: begin
            data_next    = '0;
            ovf_out_next = 1'b0;
         end
      endcase
   end

   // Each channel owns its own registers; only the addressed one ever loads.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ACC_WIDTH-1:0] acc_reg;
      logic                 ovf_reg;
      logic                 hit;

      assign hit = accept && (bus.in_ch == CH_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
         end else if (hit) begin
            if (op == OP_ACC) begin
               acc_reg <= acc_next;
               ovf_reg <= ovf_next;
            end else if (op == OP_CLR) begin
               acc_reg <= '0;
               ovf_reg <= 1'b0;
            end
         end
      end

      assign acc_q[gi] = acc_reg;
      assign ovf_q[gi] = ovf_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         out_ovf_reg   <= 1'b0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= data_next;
         out_ch_reg    <= bus.in_ch;
         out_ovf_reg   <= ovf_out_next;
      end else if (bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.out_ch    = out_ch_reg;
   assign bus.out_ovf   = out_ovf_reg;
endmodule

// File: tb/tb_multi_acc.sv
// Directed bench for multi_acc: reset, ADD/ACC/CLR/READ, backpressure, overflow and mid-stream reset.
module tb_multi_acc;
   localparam int WIDTH     = 8;
   localparam int CHANNELS  = 4;
   localparam int ACC_WIDTH = 16;
   localparam logic [1:0] ADD = 2'd0, ACC = 2'd1, CLR = 2'd2, READ = 2'd3;

`ifdef MULTI_ACC_SAT_EN
   localparam logic [15:0] OVF_RESULT = 16'hFFFF;
`else
   localparam logic [15:0] OVF_RESULT = 16'h0005;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   multi_acc_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ACC_WIDTH(ACC_WIDTH)) bus ();

   multi_acc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ACC_WIDTH(ACC_WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [1:0] ch, input logic [15:0] data,
                            input logic ovf);
      check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".data"},  32'(bus.out_data),  32'(data));
      check({tag, ".ch"},    32'(bus.out_ch),    32'(ch));
      check({tag, ".ovf"},   32'(bus.out_ovf),   32'(ovf));
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] ch,
                        input logic [7:0] a, input logic [7:0] b);
      bus.in_valid = v;
      bus.in_op    = op;
      bus.in_ch    = ch;
      bus.in_a     = a;
      bus.in_b     = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] ch,
                        input logic [7:0] a, input logic [7:0] b);
      drive(1'b1, op, ch, a, b);
      tick();
      $display("txn op=%0d ch=%0d a=0x%02h b=0x%02h -> valid=%0b data=0x%04h ch=%0d ovf=%0b",
               op, ch, a, b, bus.out_valid, bus.out_data, bus.out_ch, bus.out_ovf);
   endtask

   initial begin
      drive(1'b0, ADD, 2'd0, 8'h00, 8'h00);
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst.valid", 32'(bus.out_valid), 32'd0);
      check("rst.data",  32'(bus.out_data),  32'd0);
      check("rst.ready", 32'(bus.in_ready),  32'd1);
      tick();
      tick();
      check("rst.hold.valid", 32'(bus.out_valid), 32'd0);
      #2 rst_n = 1'b1;
      #1 check("post_rst.ready", 32'(bus.in_ready), 32'd1);

      // ADD is combinational on operands only.
      issue(ADD, 2'd1, 8'hFF, 8'hFF);
      check_out("add_ff", 2'd1, 16'h01FE, 1'b0);
      issue(READ, 2'd1, 8'h00, 8'h00);
      check_out("read1_after_add", 2'd1, 16'd0, 1'b0);

      // Back-to-back accumulation on ch2.
      issue(ACC, 2'd2, 8'd10, 8'd20);
      check_out("acc2_a", 2'd2, 16'd30, 1'b0);
      issue(ACC, 2'd2, 8'd5, 8'd5);
      check_out("acc2_b", 2'd2, 16'd40, 1'b0);
      check("flow.ready", 32'(bus.in_ready), 32'd1);
      issue(READ, 2'd2, 8'h00, 8'h00);
      check_out("read2", 2'd2, 16'd40, 1'b0);
      issue(READ, 2'd1, 8'h00, 8'h00);
      check_out("read1", 2'd1, 16'd0, 1'b0);

      drive(1'b0, ACC, 2'd2, 8'hAA, 8'h55);
      tick();
      check("drain.valid", 32'(bus.out_valid), 32'd0);

      // Backpressure: result held, stalled transaction not applied until release.
      bus.out_ready = 1'b0;
      issue(ACC, 2'd2, 8'd1, 8'd2);
      check_out("bp_first", 2'd2, 16'd43, 1'b0);
      drive(1'b1, ACC, 2'd2, 8'd100, 8'd100);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp.ready", 32'(bus.in_ready), 32'd0);
         check("bp.data",  32'(bus.out_data), 32'd43);
         check("bp.valid", 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      #1 check("bp.release.ready", 32'(bus.in_ready), 32'd1);
      tick();
      check_out("bp_release", 2'd2, 16'd243, 1'b0);
      issue(READ, 2'd2, 8'h00, 8'h00);
      check_out("read2_after_bp", 2'd2, 16'd243, 1'b0);

      // Drive ch0 to 0xFFF0 (128 * 0x1FE + 0xF0), then overflow it.
      issue(CLR, 2'd0, 8'h12, 8'h34);
      check_out("clr0_pre", 2'd0, 16'd0, 1'b0);
      for (int i = 0; i < 128; i++) issue(ACC, 2'd0, 8'hFF, 8'hFF);
      check_out("preload_mid", 2'd0, 16'hFF00, 1'b0);
      issue(ACC, 2'd0, 8'hF0, 8'h00);
      check_out("preload", 2'd0, 16'hFFF0, 1'b0);
      issue(ACC, 2'd0, 8'h10, 8'h05);
      check_out("ovf", 2'd0, OVF_RESULT, 1'b1);
      issue(ACC, 2'd0, 8'h00, 8'h00);
      check_out("ovf_sticky", 2'd0, OVF_RESULT, 1'b1);
      issue(READ, 2'd0, 8'h00, 8'h00);
      check_out("read0_ovf", 2'd0, OVF_RESULT, 1'b1);
      issue(ADD, 2'd0, 8'h01, 8'h02);
      check_out("add_no_ovf", 2'd0, 16'd3, 1'b0);
      issue(READ, 2'd1, 8'h00, 8'h00);
      check_out("read1_isolated", 2'd1, 16'd0, 1'b0);
      issue(CLR, 2'd0, 8'h00, 8'h00);
      check_out("clr0", 2'd0, 16'd0, 1'b0);
      issue(READ, 2'd0, 8'h00, 8'h00);
      check_out("read0_cleared", 2'd0, 16'd0, 1'b0);

      // Asynchronous reset with a pending, stalled result.
      issue(ACC, 2'd2, 8'd7, 8'd0);
      check_out("pre_rst", 2'd2, 16'd250, 1'b0);
      bus.out_ready = 1'b0;
      drive(1'b0, ADD, 2'd0, 8'h00, 8'h00);
      #3 rst_n = 1'b0;
      #1;
      check("arst.valid", 32'(bus.out_valid), 32'd0);
      check("arst.data",  32'(bus.out_data),  32'd0);
      check("arst.ch",    32'(bus.out_ch),    32'd0);
      check("arst.ovf",   32'(bus.out_ovf),   32'd0);
      check("arst.ready", 32'(bus.in_ready),  32'd1);
      tick();
      #2 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      check("post_arst.valid", 32'(bus.out_valid), 32'd0);
      issue(READ, 2'd2, 8'h00, 8'h00);
      check_out("read2_after_rst", 2'd2, 16'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
